// File: rtl/pkt_fifo_if.sv
// Handshake bundle for pkt_fifo. The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface pkt_fifo_if #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned LOG2_FIFO_DEPTH = 11
);
    logic                       wr_en;
    logic [DATA_W-1:0]          wr_data;
    logic                       wr_last;
    logic                       wr_drop;
    logic                       full;
    logic                       almost_full;
    logic                       overflow;
    logic                       rd_en;
    logic                       rd_valid;
    logic [DATA_W-1:0]          rd_data;
    logic                       rd_last;
    logic [LOG2_FIFO_DEPTH:0]   fill_count;
    logic [LOG2_FIFO_DEPTH:0]   pkt_count;

    modport master (
        output wr_en, wr_data, wr_last, wr_drop, rd_en,
        input  full, almost_full, overflow, rd_valid, rd_data, rd_last, fill_count, pkt_count
    );

    modport slave (
        input  wr_en, wr_data, wr_last, wr_drop, rd_en,
        output full, almost_full, overflow, rd_valid, rd_data, rd_last, fill_count, pkt_count
    );
endinterface

// File: rtl/pkt_fifo.sv
// Frame-aware FWFT FIFO. Beats become readable only after their frame commits, and frames roll back on drop or overflow.
// Defining PKT_FIFO_STATS_EN adds saturating commit/drop/overflow statistics counters.
module pkt_fifo #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned LOG2_FIFO_DEPTH = 11,
    parameter int unsigned AFULL_THRESH    = 2040
) (
    input  logic        clk,
    input  logic        rst,
    pkt_fifo_if.slave   bus
`ifdef PKT_FIFO_STATS_EN
    ,
    output logic [31:0] stat_commit_cnt,
    output logic [31:0] stat_drop_cnt,
    output logic [31:0] stat_ovf_cnt
`endif
);
    localparam int unsigned PW    = LOG2_FIFO_DEPTH + 1;
    localparam int unsigned AW    = LOG2_FIFO_DEPTH;
    localparam int unsigned DEPTH = 1 << LOG2_FIFO_DEPTH;

    typedef logic [PW-1:0] ptr_t;
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;
    typedef enum logic [1:0] {WR_IDLE, WR_IN_PKT, WR_DISCARD} wr_state_e;

    wr_state_e state_q, state_d;
    ptr_t      wr_ptr_q, wr_ptr_d;
    ptr_t      commit_ptr_q, commit_ptr_d;
    ptr_t      commit_vis_q;
    ptr_t      rd_ptr_q, rd_ptr_d;
    ptr_t      fill_count_q, fill_count_d;
    ptr_t      pkt_count_q, pkt_count_d;
    logic      full_q, full_d;
    logic      almost_full_q, almost_full_d;
    logic      overflow_q, overflow_d;
    logic      rd_valid_q, rd_valid_d;
    beat_t     rd_beat_q, rd_beat_d;
    beat_t     mem_q [DEPTH];
    beat_t     wr_beat;
    logic      mem_we;
    logic      commit;
    logic      frame_ovf;
    logic      empty;
    logic      load;
    logic      xfer;

    // Write side: speculative pointer advances per beat, commit pointer advances per frame.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        commit       = 1'b0;
        frame_ovf    = 1'b0;
        wr_beat      = {bus.wr_last, bus.wr_data};
        case (state_q)
            WR_DISCARD: begin
                if (bus.wr_en && bus.wr_last) state_d = WR_IDLE;
            end
            default: begin
                if (bus.wr_drop) begin
                    wr_ptr_d = commit_ptr_q;
                    state_d  = WR_IDLE;
                end else if (bus.wr_en && full_q) begin
                    wr_ptr_d  = commit_ptr_q;
                    frame_ovf = 1'b1;
                    state_d   = bus.wr_last ? WR_IDLE : WR_DISCARD;
                end else if (bus.wr_en) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (bus.wr_last) begin
                        commit       = 1'b1;
                        commit_ptr_d = wr_ptr_q + PW'(1);
                        state_d      = WR_IDLE;
                    end else begin
                        state_d = WR_IN_PKT;
                    end
                end
            end
        endcase
    end

    // Read side: commit visibility trails by one cycle to model the memory read latency.
    always_comb begin
        empty      = (commit_vis_q == rd_ptr_q);
        xfer       = rd_valid_q && bus.rd_en;
        load       = (!rd_valid_q || bus.rd_en) && !empty;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q && !bus.rd_en;
        rd_beat_d  = rd_beat_q;
        if (load) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            rd_valid_d = 1'b1;
            rd_beat_d  = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Status flags are computed from the post-edge pointer values.
    always_comb begin
        pkt_count_d   = pkt_count_q + PW'(commit) - PW'(xfer && rd_beat_q.last);
        fill_count_d  = wr_ptr_d - rd_ptr_d;
        full_d        = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        almost_full_d = (fill_count_d >= PW'(AFULL_THRESH));
        overflow_d    = frame_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WR_IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            commit_vis_q  <= '0;
            rd_ptr_q      <= '0;
            fill_count_q  <= '0;
            pkt_count_q   <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_beat_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            commit_vis_q  <= commit_ptr_q;
            rd_ptr_q      <= rd_ptr_d;
            fill_count_q  <= fill_count_d;
            pkt_count_q   <= pkt_count_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            rd_valid_q    <= rd_valid_d;
            rd_beat_q     <= rd_beat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= wr_beat;
    end

    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_beat_q.data;
    assign bus.rd_last     = rd_beat_q.last;
    assign bus.fill_count  = fill_count_q;
    assign bus.pkt_count   = pkt_count_q;

`ifdef PKT_FIFO_STATS_EN
    logic [31:0] stat_commit_q, stat_commit_d;
    logic [31:0] stat_drop_q, stat_drop_d;
    logic [31:0] stat_ovf_q, stat_ovf_d;
    logic        frame_drop;

    // Dropping counts only when a beat or an open frame is actually discarded.
    always_comb begin
        frame_drop    = (state_q != WR_DISCARD) && bus.wr_drop && (bus.wr_en || (state_q == WR_IN_PKT));
        stat_commit_d = stat_commit_q + ((commit     && (stat_commit_q != '1)) ? 32'd1 : 32'd0);
        stat_drop_d   = stat_drop_q   + ((frame_drop && (stat_drop_q   != '1)) ? 32'd1 : 32'd0);
        stat_ovf_d    = stat_ovf_q    + ((frame_ovf  && (stat_ovf_q    != '1)) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_commit_q <= '0;
            stat_drop_q   <= '0;
            stat_ovf_q    <= '0;
        end else begin
            stat_commit_q <= stat_commit_d;
            stat_drop_q   <= stat_drop_d;
            stat_ovf_q    <= stat_ovf_d;
        end
    end

    assign stat_commit_cnt = stat_commit_q;
    assign stat_drop_cnt   = stat_drop_q;
    assign stat_ovf_cnt    = stat_ovf_q;
`endif
endmodule

// File: tb/tb_pkt_fifo.sv
// Self-checking bench for pkt_fifo at depth 128: queue-based frame model, randomized frames, drops and read back-pressure.
module tb_pkt_fifo;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LOG2_D = 7;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned AFULL  = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_fifo_if #(.DATA_W(DATA_W), .LOG2_FIFO_DEPTH(LOG2_D)) bus ();

`ifdef PKT_FIFO_STATS_EN
    logic [31:0] stat_commit_cnt, stat_drop_cnt, stat_ovf_cnt;
    pkt_fifo #(.DATA_W(DATA_W), .LOG2_FIFO_DEPTH(LOG2_D), .AFULL_THRESH(AFULL)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stat_commit_cnt(stat_commit_cnt), .stat_drop_cnt(stat_drop_cnt), .stat_ovf_cnt(stat_ovf_cnt));
`else
    pkt_fifo #(.DATA_W(DATA_W), .LOG2_FIFO_DEPTH(LOG2_D), .AFULL_THRESH(AFULL)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    int n_pass  = 0;
    int n_total = 0;
    int ovf_cnt = 0;
    logic [DATA_W:0] got_q[$];
    logic [DATA_W:0] exp_q[$];

    // Advance one clock; transfers are recorded from the values in force before the edge.
    task automatic step();
        if (bus.rd_valid && bus.rd_en) got_q.push_back({bus.rd_last, bus.rd_data});
        @(posedge clk);
        #1;
        if (bus.overflow) ovf_cnt++;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input bit last, input bit drop);
        bus.wr_en = 1'b1; bus.wr_data = d; bus.wr_last = last; bus.wr_drop = drop;
        step();
        bus.wr_en = 1'b0; bus.wr_last = 1'b0; bus.wr_drop = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.rd_en = 1'b1;
        for (int k = 0; k < 400 && (got_q.size() < n || bus.rd_valid); k++) step();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.rd_valid, bus.rd_data, bus.rd_last, bus.full, bus.almost_full, bus.overflow,
             bus.fill_count, bus.pkt_count} !== '0)
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b full=%b af=%b ovf=%b fill=%0d pkt=%0d required all 0",
                     bus.rd_valid, bus.rd_data, bus.rd_last, bus.full, bus.almost_full, bus.overflow,
                     bus.fill_count, bus.pkt_count);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        logic [DATA_W-1:0] d;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 64; i++) begin
            d = DATA_W'($urandom);
            exp_q.push_back({(i == 63), d});
            send_beat(d, (i == 63), 1'b0);
        end
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL t1_valid_e0: got %b required 0", bus.rd_valid); else n_pass++;
        step();
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL t1_valid_e1: got %b required 0", bus.rd_valid); else n_pass++;
        step();
        n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL t1_valid_e2: got %b required 1", bus.rd_valid); else n_pass++;
        n_total++; if (bus.pkt_count !== 8'd1) $display("FAIL t1_pkt_1: got %0d required 1", bus.pkt_count); else n_pass++;
        n_total++; if (bus.fill_count !== 8'd63) $display("FAIL t1_fill_63: got %0d required 63", bus.fill_count); else n_pass++;
        bus.rd_en = 1'b1;
        repeat (64) step();
        bus.rd_en = 1'b0;
        n_total++; if (got_q.size() != 64) $display("FAIL t1_rate: got %0d beats in 64 cycles required 64", got_q.size()); else n_pass++;
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t1_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (bus.pkt_count !== 8'd0) $display("FAIL t1_pkt_0: got %0d required 0", bus.pkt_count); else n_pass++;
        n_total++; if (bus.fill_count !== 8'd0) $display("FAIL t1_fill_0: got %0d required 0", bus.fill_count); else n_pass++;
    endtask

    task automatic test_drop();
        bit seen_valid = 1'b0;
        got_q.delete();
        for (int i = 0; i < 19; i++) send_beat(DATA_W'($urandom), 1'b0, 1'b0);
        n_total++; if (bus.fill_count !== 8'd19) $display("FAIL t2_fill_19: got %0d required 19", bus.fill_count); else n_pass++;
        send_beat(DATA_W'($urandom), 1'b1, 1'b1);
        n_total++; if (bus.fill_count !== 8'd0) $display("FAIL t2_fill_0: got %0d required 0", bus.fill_count); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (bus.rd_valid) seen_valid = 1'b1;
            step();
        end
        n_total++; if (seen_valid) $display("FAIL t2_no_valid: got rd_valid=1 required 0"); else n_pass++;
        n_total++; if (bus.pkt_count !== 8'd0) $display("FAIL t2_pkt: got %0d required 0", bus.pkt_count); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] d;
        ovf_cnt = 0;
        for (int i = 1; i <= DEPTH + 4; i++) begin
            send_beat(DATA_W'($urandom), (i == DEPTH + 4), 1'b0);
            if (i == AFULL - 1) begin
                n_total++; if (bus.almost_full !== 1'b0) $display("FAIL t3_af_below: got %b required 0", bus.almost_full); else n_pass++;
            end
            if (i == AFULL) begin
                n_total++; if (bus.almost_full !== 1'b1) $display("FAIL t3_af_at: got %b required 1", bus.almost_full); else n_pass++;
            end
            if (i == DEPTH - 1) begin
                n_total++; if (bus.full !== 1'b0) $display("FAIL t3_not_full: got %b required 0", bus.full); else n_pass++;
            end
            if (i == DEPTH) begin
                n_total++; if (bus.full !== 1'b1) $display("FAIL t3_full: got %b required 1", bus.full); else n_pass++;
                n_total++; if (bus.fill_count !== 8'(DEPTH)) $display("FAIL t3_fill_depth: got %0d required %0d", bus.fill_count, DEPTH); else n_pass++;
            end
        end
        step(); step();
        n_total++; if (ovf_cnt != 1) $display("FAIL t3_ovf_pulses: got %0d required 1", ovf_cnt); else n_pass++;
        n_total++; if (bus.fill_count !== 8'd0) $display("FAIL t3_fill_0: got %0d required 0", bus.fill_count); else n_pass++;
        n_total++; if (bus.full !== 1'b0 || bus.rd_valid !== 1'b0) $display("FAIL t3_after: got full=%b valid=%b required 0/0", bus.full, bus.rd_valid); else n_pass++;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++) begin
            d = DATA_W'($urandom);
            exp_q.push_back({(i == 3), d});
            send_beat(d, (i == 3), 1'b0);
        end
        drain(4);
        n_total++; if (got_q.size() != 4) $display("FAIL t3_next_len: got %0d required 4", got_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t3_next_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_commit_read_overlap();
        logic [DATA_W-1:0] d;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 3; i++) begin
            d = DATA_W'($urandom); exp_q.push_back({(i == 2), d}); send_beat(d, (i == 2), 1'b0);
        end
        step(); step(); step();
        n_total++; if (bus.pkt_count !== 8'd1) $display("FAIL t4_pkt_a: got %0d required 1", bus.pkt_count); else n_pass++;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = DATA_W'($urandom); exp_q.push_back({(i == 2), d}); send_beat(d, (i == 2), 1'b0);
        end
        n_total++; if (got_q.size() != 3) $display("FAIL t4_rate: got %0d beats required 3", got_q.size()); else n_pass++;
        n_total++; if (bus.pkt_count !== 8'd1) $display("FAIL t4_pkt_overlap: got %0d required 1", bus.pkt_count); else n_pass++;
        drain(6);
        n_total++; if (got_q.size() != 6) $display("FAIL t4_len: got %0d required 6", got_q.size()); else n_pass++;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t4_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (bus.pkt_count !== 8'd0) $display("FAIL t4_pkt_0: got %0d required 0", bus.pkt_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int len, mode;
        logic [DATA_W-1:0] d;
        exp_q.delete(); got_q.delete();
        for (int f = 0; f < 12; f++) begin
            len  = $urandom_range(1, 10);
            mode = $urandom_range(0, 4);
            for (int i = 0; i < len; i++) begin
                bus.rd_en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) step();
                d = DATA_W'($urandom);
                if (mode == 0) begin
                    send_beat(d, (i == len - 1), (i == len - 1));
                end else if (mode == 1) begin
                    send_beat(d, 1'b0, 1'b0);
                end else begin
                    exp_q.push_back({(i == len - 1), d});
                    send_beat(d, (i == len - 1), 1'b0);
                end
            end
            if (mode == 1) begin
                bus.wr_drop = 1'b1; step(); bus.wr_drop = 1'b0;
            end
        end
        drain(exp_q.size());
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL t5_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t5_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (bus.pkt_count !== 8'd0 || bus.fill_count !== 8'd0) $display("FAIL t5_counts: got pkt=%0d fill=%0d required 0/0", bus.pkt_count, bus.fill_count); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 5; i++) send_beat(DATA_W'($urandom | 1), (i == 4), 1'b0);
        step(); step();
        for (int i = 0; i < 3; i++) send_beat(DATA_W'($urandom), 1'b0, 1'b0);
        n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL t6_pre_valid: got %b required 1", bus.rd_valid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.rd_valid, bus.rd_data, bus.rd_last, bus.full, bus.almost_full, bus.overflow,
             bus.fill_count, bus.pkt_count} !== '0)
            $display("FAIL t6_async_reset: got valid=%b data=%h last=%b fill=%0d pkt=%0d required all 0",
                     bus.rd_valid, bus.rd_data, bus.rd_last, bus.fill_count, bus.pkt_count);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 2; i++) begin
            d = DATA_W'($urandom); exp_q.push_back({(i == 1), d}); send_beat(d, (i == 1), 1'b0);
        end
        drain(2);
        n_total++; if (got_q.size() != 2) $display("FAIL t6_len: got %0d required 2", got_q.size()); else n_pass++;
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t6_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

`ifdef PKT_FIFO_STATS_EN
    task automatic test_stats();
        test_reset();
        ovf_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            send_beat(DATA_W'($urandom), 1'b0, 1'b0);
            send_beat(DATA_W'($urandom), 1'b1, 1'b0);
        end
        send_beat(DATA_W'($urandom), 1'b0, 1'b0);
        send_beat(DATA_W'($urandom), 1'b1, 1'b1);
        send_beat(DATA_W'($urandom), 1'b0, 1'b0);
        bus.wr_drop = 1'b1; step(); bus.wr_drop = 1'b0;
        for (int i = 0; i < 125; i++) send_beat(DATA_W'($urandom), (i == 124), 1'b0);
        step();
        n_total++; if (stat_commit_cnt !== 32'd3) $display("FAIL t7_commit: got %0d required 3", stat_commit_cnt); else n_pass++;
        n_total++; if (stat_drop_cnt !== 32'd2) $display("FAIL t7_drop: got %0d required 2", stat_drop_cnt); else n_pass++;
        n_total++; if (stat_ovf_cnt !== 32'd1) $display("FAIL t7_ovf: got %0d required 1", stat_ovf_cnt); else n_pass++;
        got_q.delete();
        drain(6);
    endtask
`endif

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0; bus.wr_drop = 1'b0; bus.rd_en = 1'b0;
        test_reset();
        test_single_frame();
        test_drop();
        test_overflow();
        test_commit_read_overlap();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef PKT_FIFO_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
